// File: rtl/cpm_pkg.sv
// cpm_pkg: shared types and helpers for the CPM windowed accumulator.
// Holds the FSM state enum, default sizes and the sign-extension helper.
package cpm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    FULL
  } state_t;

  localparam int DW_DEF      = 12;
  localparam int WIN_MAX_DEF = 64;

  // Sign-extend the low w bits of d to 64 bits.
  function automatic logic [63:0] sext(
    input logic [63:0] d,
    input logic [5:0]  w
  );
    logic [63:0] m;
    m = ~64'd0 << w;
    sext = d[w - 6'd1] ? (d | m) : (d & ~m);
  endfunction

endpackage

// File: rtl/cpm_win_cnt.sv
// cpm_win_cnt: sample counter for one accumulation window.
// Flags the sample that completes the window and wraps to zero on it.
module cpm_win_cnt
  import cpm_pkg::*;
#(
  parameter int CW = 7
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          inc,
  input  logic [CW-1:0] win_len,
  output logic          last
);

  logic [CW-1:0] cnt;
  logic [CW-1:0] nxt;

  assign nxt  = cnt + CW'(1);
  assign last = (nxt == win_len);

  // Count accepted samples; restart after the closing sample or a flush.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= last ? '0 : nxt;
    end
  end

endmodule

// File: rtl/cpm_win_acc.sv
// cpm_win_acc: sums non-overlapping windows of signed samples.
// Each window sum is offered on a valid/ready output to the result bank.
module cpm_win_acc
  import cpm_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int WIN_MAX = WIN_MAX_DEF,
  parameter int CW      = $clog2(WIN_MAX + 1),
  parameter int AW      = DW + $clog2(WIN_MAX)
) (
  input  logic          Clk,
  input  logic          Rstn,
  input  logic          Clear,
  input  logic [CW-1:0] WinLen,
  input  logic          InVld,
  output logic          InRdy,
  input  logic [DW-1:0] InData,
  output logic          OutVld,
  input  logic          OutRdy,
  output logic [AW-1:0] OutData,
  output logic [CW-1:0] OutCnt
);

  state_t        state_q;
  state_t        state_d;
  logic [AW-1:0] acc_q;
  logic [AW-1:0] sum;
  logic [CW-1:0] win_len_q;
  logic          len_ok;
  logic          acc_in;
  logic          out_xfer;
  logic          win_ld;
  logic          last;

  assign len_ok = (WinLen != '0) &&
                  (WinLen <= CW'(WIN_MAX));

  assign sum = acc_q +
               AW'(sext(64'(InData), 6'(DW)));

  assign OutVld   = (state_q == FULL);
  assign out_xfer = OutVld & OutRdy;

  // A pending sum frees the input only when it leaves this cycle.
  assign InRdy = !Clear &&
                 ((state_q == ACC) ||
                  ((state_q == FULL) && OutRdy));

  assign acc_in = InVld & InRdy;

  cpm_win_cnt #(
    .CW (CW)
  ) u_cnt (
    .clk     (Clk),
    .rstn    (Rstn),
    .clr     (Clear),
    .inc     (acc_in),
    .win_len (win_len_q),
    .last    (last)
  );

  // Next-state and window-length load decision.
  always_comb begin
    state_d = state_q;
    win_ld  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (len_ok) begin
          state_d = ACC;
          win_ld  = 1'b1;
        end
      end
      ACC: begin
        if (acc_in && last) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (acc_in) begin
          state_d = last ? FULL : ACC;
        end else if (out_xfer) begin
          if (len_ok) begin
            state_d = ACC;
            win_ld  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (Clear) begin
      state_d = IDLE;
      win_ld  = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Accumulator, latched window length and result outputs.
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      acc_q     <= '0;
      win_len_q <= '0;
      OutData   <= '0;
      OutCnt    <= '0;
    end else begin
      if (Clear) begin
        acc_q <= '0;
      end else if (acc_in) begin
        acc_q <= last ? '0 : sum;
      end
      if (win_ld) begin
        win_len_q <= WinLen;
      end
      if (acc_in && last) begin
        OutData <= sum;
        OutCnt  <= win_len_q;
      end
    end
  end

endmodule

// File: tb/tb_cpm_win_acc.sv
// tb_cpm_win_acc: bench for the windowed accumulator.
// Vector table, directed corner cases and random traffic against a model.
module tb_cpm_win_acc;

  logic        Clk = 1'b0;
  logic        Rstn;
  logic        Clear;
  logic [6:0]  WinLen;
  logic        InVld;
  logic        InRdy;
  logic [11:0] InData;
  logic        OutVld;
  logic        OutRdy;
  logic [17:0] OutData;
  logic [6:0]  OutCnt;

  int errors = 0;
  int checks = 0;

  bit     m_started;
  bit     m_pend;
  int     m_wl;
  int     m_q[$];
  longint m_od;
  int     m_oc;

  typedef struct {
    int wl;
    int first;
    int step;
    int exp;
  } vec_t;

  vec_t tbl[6];

  always #5 Clk = ~Clk;

  cpm_win_acc dut (
    .Clk     (Clk),
    .Rstn    (Rstn),
    .Clear   (Clear),
    .WinLen  (WinLen),
    .InVld   (InVld),
    .InRdy   (InRdy),
    .InData  (InData),
    .OutVld  (OutVld),
    .OutRdy  (OutRdy),
    .OutData (OutData),
    .OutCnt  (OutCnt)
  );

  task automatic chk(input string nm,
                     input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d",
               nm, act, exp);
    end
  endtask

  function automatic bit legal(input int w);
    return (w >= 1) && (w <= 64);
  endfunction

  task automatic model_reset();
    m_started = 0;
    m_pend    = 0;
    m_wl      = 0;
    m_q.delete();
    m_od      = 0;
    m_oc      = 0;
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic tick();
    bit er;
    bit a;
    bit x;
    bit clr;
    int din;
    int wl_in;
    longint s;
    #4;
    er = !Clear && m_started &&
         (!m_pend || OutRdy);
    chk("in_rdy", InRdy, er);
    chk("out_vld", OutVld, m_pend);
    a     = InVld && er;
    x     = m_pend && OutRdy;
    clr   = Clear;
    din   = int'($signed(InData));
    wl_in = int'(WinLen);
    @(posedge Clk);
    if (clr) begin
      m_started = 0;
      m_pend    = 0;
      m_q.delete();
    end else if (!m_started) begin
      if (legal(wl_in)) begin
        m_wl      = wl_in;
        m_started = 1;
      end
    end else begin
      if (x) m_pend = 0;
      if (a) begin
        m_q.push_back(din);
        if (m_q.size() == m_wl) begin
          s = 0;
          foreach (m_q[i]) s += m_q[i];
          m_od   = s;
          m_oc   = m_wl;
          m_pend = 1;
          m_q.delete();
        end
      end
      if (x && !a) begin
        if (legal(wl_in)) m_wl = wl_in;
        else m_started = 0;
      end
    end
    #1;
    chk("out_vld_q", OutVld, m_pend);
    chk("out_data", $signed(OutData), m_od);
    chk("out_cnt", OutCnt, m_oc);
  endtask

  task automatic feed(input int d);
    InVld  = 1'b1;
    InData = 12'(d);
    tick();
    InVld  = 1'b0;
  endtask

  task automatic start(input int wl);
    Clear  = 1'b1;
    tick();
    Clear  = 1'b0;
    WinLen = 7'(wl);
    tick();
    WinLen = 7'd0;
  endtask

  initial begin
    int lens[8];
    lens = '{0, 1, 2, 3, 5, 64, 100, 7};
    tbl[0] = '{4, 1, 1, 10};
    tbl[1] = '{64, -2048, 0, -131072};
    tbl[2] = '{64, 2047, 0, 131008};
    tbl[3] = '{1, -5, 0, -5};
    tbl[4] = '{3, -1, -1, -6};
    tbl[5] = '{5, 100, -50, 0};

    Rstn   = 1'b0;
    Clear  = 1'b0;
    WinLen = 7'd0;
    InVld  = 1'b0;
    InData = 12'd0;
    OutRdy = 1'b1;
    model_reset();
    #12 Rstn = 1'b1;
    @(posedge Clk);
    #1;
    chk("rst_in_rdy", InRdy, 0);
    chk("rst_out_vld", OutVld, 0);
    chk("rst_out_data", OutData, 0);
    chk("rst_out_cnt", OutCnt, 0);

    // illegal length keeps IDLE
    repeat (3) tick();
    chk("idle_rdy", InRdy, 0);
    WinLen = 7'd3;
    tick();
    tick();
    chk("rdy_after_len", InRdy, 1);
    WinLen = 7'd0;
    OutRdy = 1'b0;
    feed(7);
    feed(-2);
    feed(5);
    chk("pre_rst_vld", OutVld, 1);
    chk("pre_rst_data", $signed(OutData), 10);

    // async reset while a sum is pending
    #2 Rstn = 1'b0;
    #1;
    chk("arst_vld", OutVld, 0);
    chk("arst_data", OutData, 0);
    chk("arst_cnt", OutCnt, 0);
    model_reset();
    @(negedge Clk);
    Rstn   = 1'b1;
    OutRdy = 1'b1;
    @(posedge Clk);
    #1;

    // vector table
    for (int t = 0; t < 6; t++) begin
      start(tbl[t].wl);
      OutRdy = 1'b1;
      for (int i = 0; i < tbl[t].wl; i++)
        feed(tbl[t].first + i * tbl[t].step);
      chk("tbl_vld", OutVld, 1);
      chk("tbl_sum", $signed(OutData), tbl[t].exp);
      chk("tbl_cnt", OutCnt, tbl[t].wl);
      tick();
    end

    // backpressure
    start(2);
    OutRdy = 1'b0;
    feed(5);
    feed(6);
    InVld  = 1'b1;
    InData = 12'd9;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_vld", OutVld, 1);
      chk("bp_data", $signed(OutData), 11);
      chk("bp_rdy", InRdy, 0);
    end
    OutRdy = 1'b1;
    InData = 12'd7;
    tick();
    chk("bp_vld_drop", OutVld, 0);
    InVld = 1'b0;
    feed(8);
    chk("bp_next_sum", $signed(OutData), 15);
    tick();

    // streaming at length 1
    start(1);
    OutRdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      InVld  = 1'b1;
      InData = 12'(i);
      tick();
      chk("stream_vld", OutVld, 1);
      chk("stream_data", $signed(OutData), i);
    end
    InVld = 1'b0;
    tick();

    // clear mid-window
    start(4);
    feed(1);
    feed(2);
    feed(3);
    Clear  = 1'b1;
    InVld  = 1'b1;
    InData = 12'd9;
    tick();
    Clear = 1'b0;
    InVld = 1'b0;
    chk("clr_vld", OutVld, 0);
    chk("clr_rdy", InRdy, 0);
    WinLen = 7'd4;
    tick();
    WinLen = 7'd0;
    for (int i = 0; i < 4; i++) feed(1);
    chk("clr_next_vld", OutVld, 1);
    chk("clr_next_sum", $signed(OutData), 4);
    tick();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      Clear  = ($urandom % 30) == 0;
      InVld  = $urandom % 2;
      OutRdy = ($urandom % 4) != 0;
      InData = 12'($urandom);
      WinLen = 7'(lens[$urandom % 8]);
      tick();
    end
    Clear = 1'b0;
    InVld = 1'b0;

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
